// File: rtl/weight_fetcher.sv
// weight_fetcher: walks every filter/channel pair of a conv layer, issues one
// single-cycle ROM read per pair and streams the returned kernels, tagged with
// their indices, through a 2-entry valid/ready output buffer.
// Optional feature: define WEIGHT_FETCH_TIMEOUT_EN to build the response
// watchdog (sticky error, buffer flush and return to idle).
module weight_fetcher #(
  parameter int unsigned NUM_FILTERS    = 3,
  parameter int unsigned INPUT_CHANNELS = 3,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned WEIGHT_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  localparam int unsigned KW = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH,
  localparam int unsigned FW = $clog2(NUM_FILTERS),
  localparam int unsigned CW = $clog2(INPUT_CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [FW-1:0] rom_filter_idx,
  output logic [CW-1:0] rom_channel_idx,
  output logic          rom_read_enable,
  input  logic [KW-1:0] rom_weight_in,
  input  logic          rom_weight_valid,
  output logic [KW-1:0] out_weight,
  output logic [FW-1:0] out_filter_idx,
  output logic [CW-1:0] out_channel_idx,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [FW-1:0] LastF = FW'(NUM_FILTERS - 1);
  localparam logic [CW-1:0] LastC = CW'(INPUT_CHANNELS - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StHold, StDrain} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] f_q, f_d;
  logic [CW-1:0] c_q, c_d;

  // Output buffer storage
  logic [KW-1:0] buf_w_q [2];
  logic [FW-1:0] buf_f_q [2];
  logic [CW-1:0] buf_c_q [2];
  logic          buf_l_q [2];
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    count_q, count_d;

  logic push, pop, is_last, timeout;

  assign is_last   = (f_q == LastF) && (c_q == LastC);
  // Responses outside WAIT are ignored by construction
  assign push      = (state_q == StWait) && rom_weight_valid;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

`ifdef WEIGHT_FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt_q;
  logic          error_q;

  // Count consecutive WAIT cycles without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != StWait || rom_weight_valid) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + TW'(1);
    end
  end

  assign timeout = (state_q == StWait) && !rom_weight_valid &&
                   (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Sticky error, cleared only by an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      error_q <= 1'b0;
    end else if (timeout) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // FSM state and pair counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      f_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      c_q     <= c_d;
    end
  end

  // Next-state logic; issue only when the buffer can absorb the response
  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    c_d     = c_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          f_d     = '0;
          c_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (rom_weight_valid) begin
          if (is_last) begin
            state_d = StDrain;
          end else begin
            if (c_q == LastC) begin
              c_d = '0;
              f_d = f_q + FW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
            state_d = (count_d <= 2'd1) ? StIssue : StHold;
          end
        end else if (timeout) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (count_q <= 2'd1) state_d = StIssue;
      end
      StDrain: begin
        if (count_q == 2'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // 2-entry FIFO; simultaneous push and pop keep occupancy unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_w_q[i] <= '0;
        buf_f_q[i] <= '0;
        buf_c_q[i] <= '0;
        buf_l_q[i] <= 1'b0;
      end
    end else if (timeout) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        buf_w_q[wr_ptr_q] <= rom_weight_in;
        buf_f_q[wr_ptr_q] <= f_q;
        buf_c_q[wr_ptr_q] <= c_q;
        buf_l_q[wr_ptr_q] <= is_last;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  // Outputs; head data is zeroed when the buffer is empty
  assign rom_read_enable = (state_q == StIssue);
  assign rom_filter_idx  = f_q;
  assign rom_channel_idx = c_q;
  assign done            = (state_q == StDrain) && (count_q == 2'd0);
  assign busy            = (state_q != StIdle) && !done;
  assign out_weight      = out_valid ? buf_w_q[rd_ptr_q] : '0;
  assign out_filter_idx  = out_valid ? buf_f_q[rd_ptr_q] : '0;
  assign out_channel_idx = out_valid ? buf_c_q[rd_ptr_q] : '0;
  assign out_last        = out_valid ? buf_l_q[rd_ptr_q] : 1'b0;

endmodule
